cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 103 ++++++++++
 tb/tb_cache_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one physical memory port between the I-cache and D-cache.
// One line transaction is in flight at a time; responses pass straight through from memory.
module cache_arbiter #(
   parameter int unsigned LINE_W = 128,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

   state_e state_q, state_d;
   // Set when the D-cache held the most recent grant.
   logic   last_d_q, last_d_d;
   logic   d_pending;

   assign d_pending = d_read | d_write;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      case (state_q)
         StIdle: begin
            if (i_read && d_pending) begin
               if (last_d_q) begin
                  state_d  = StServeI;
                  last_d_d = 1'b0;
               end else begin
                  state_d  = StServeD;
                  last_d_d = 1'b1;
               end
            end else if (i_read) begin
               state_d  = StServeI;
               last_d_d = 1'b0;
            end else if (d_pending) begin
               state_d  = StServeD;
               last_d_d = 1'b1;
            end
         end
         StServeI: if (pmem_resp) state_d = StIdle;
         StServeD: if (pmem_resp) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
      end
   end

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      i_rdata      = pmem_rdata;
      d_rdata      = pmem_rdata;
      case (state_q)
         StServeI: begin
            pmem_read    = 1'b1;
            pmem_address = {i_address[ADDR_W-1:4], 4'b0000};
            i_resp       = pmem_resp;
         end
         StServeD: begin
            // A writeback wins if the D-cache raises read and write together.
            pmem_write   = d_write;
            pmem_read    = d_read & ~d_write;
            pmem_address = {d_address[ADDR_W-1:4], 4'b0000};
            pmem_wdata   = d_wdata;
            d_resp       = pmem_resp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a memory model answers after three cycles and a monitor
// pops the expected grant order on every cache response.
module tb_cache_arbiter;

   localparam int unsigned LINE_W = 128;
   localparam int unsigned ADDR_W = 16;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              rd;
      logic              wr;
      logic [LINE_W-1:0] wdata;
   } req_t;

   typedef struct {
      logic              is_d;
      logic [ADDR_W-1:0] addr;
      logic              wr;
      logic [LINE_W-1:0] wdata;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   req_t i_q[$];
   req_t d_q[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   i_done = 1'b0;
   bit   d_done = 1'b0;
   int   mem_cnt = 0;

   cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] rdata_of(input logic [ADDR_W-1:0] a);
      return {8{a ^ 16'h5a5a}};
   endfunction

   task automatic chk(input string name, input logic [LINE_W-1:0] act,
                      input logic [LINE_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // One clock: memory model then requesters, all updated 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (pmem_resp) begin
         pmem_resp = 1'b0;
         mem_cnt   = 0;
      end else if (pmem_read || pmem_write) begin
         mem_cnt++;
         if (mem_cnt == 3) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rdata_of(pmem_address);
         end
      end else begin
         mem_cnt = 0;
      end
      if (i_done) begin
         i_done = 1'b0;
         if (i_q.size() > 0) void'(i_q.pop_front());
      end
      if (d_done) begin
         d_done = 1'b0;
         if (d_q.size() > 0) void'(d_q.pop_front());
      end
      i_read    = i_q.size() > 0;
      i_address = i_read ? i_q[0].addr : '0;
      if (d_q.size() > 0) begin
         d_read    = d_q[0].rd;
         d_write   = d_q[0].wr;
         d_address = d_q[0].addr;
         d_wdata   = d_q[0].wdata;
      end else begin
         d_read    = 1'b0;
         d_write   = 1'b0;
         d_address = '0;
         d_wdata   = '0;
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() > 0 || i_q.size() > 0 || d_q.size() > 0) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: %0d responses still outstanding, expected 0", name,
                  exp_q.size());
      end
      step();
   endtask

   task automatic push_i(input logic [ADDR_W-1:0] a);
      req_t r;
      r.addr = a; r.rd = 1'b1; r.wr = 1'b0; r.wdata = '0;
      i_q.push_back(r);
   endtask

   task automatic push_d(input logic [ADDR_W-1:0] a, input logic rd, input logic wr,
                         input logic [LINE_W-1:0] wd);
      req_t r;
      r.addr = a; r.rd = rd; r.wr = wr; r.wdata = wd;
      d_q.push_back(r);
   endtask

   task automatic expect_txn(input logic is_d, input logic [ADDR_W-1:0] a, input logic wr,
                             input logic [LINE_W-1:0] wd);
      exp_t e;
      e.is_d = is_d; e.addr = a; e.wr = wr; e.wdata = wd;
      exp_q.push_back(e);
   endtask

   // Monitor: samples on the falling edge, away from stimulus updates.
   initial begin
      exp_t e;
      bit   prev_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_resp = 1'b0;
            continue;
         end
         if (prev_resp) chk("idle_gap_strobes", {pmem_read, pmem_write}, '0);
         if (pmem_resp && (pmem_read || pmem_write)) chk("resp_passthrough", i_resp | d_resp, 1);
         if (i_resp || d_resp) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_resp: got i_resp=%b d_resp=%b expected none",
                        i_resp, d_resp);
            end else begin
               e = exp_q.pop_front();
               chk("resp_port_is_d", d_resp, e.is_d);
               chk("other_resp", e.is_d ? i_resp : d_resp, 0);
               chk("pmem_address", pmem_address, e.addr);
               chk("pmem_write", pmem_write, e.wr);
               chk("pmem_read", pmem_read, !e.wr);
               if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
               else chk("rdata", e.is_d ? d_rdata : i_rdata, rdata_of(e.addr));
            end
            if (d_resp) d_done = 1'b1;
            else i_done = 1'b1;
         end
         prev_resp = i_resp | d_resp;
      end
   end

   initial begin
      rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
      d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
      repeat (3) step();
      chk("reset_idle", {pmem_read, pmem_write, i_resp, d_resp}, '0);
      rst = 1'b0;
      step();

      // I-cache read alone, unaligned address.
      push_i(16'h1236);
      expect_txn(1'b0, 16'h1230, 1'b0, '0);
      step();
      step();
      chk("latency_pmem_read", pmem_read, 1);
      chk("latency_pmem_address", pmem_address, 16'h1230);
      wait_drain("i_read");

      // D-cache writeback.
      push_d(16'h2000, 1'b0, 1'b1, {16{8'hA5}});
      expect_txn(1'b1, 16'h2000, 1'b1, {16{8'hA5}});
      wait_drain("d_write");

      // Contention after reset: D first, then strict alternation.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_i(16'h1000 + 16'(k * 16) + 16'h3);
         push_d(16'h3000 + 16'(k * 16), 1'b1, 1'b0, '0);
      end
      for (int k = 0; k < 4; k++) begin
         expect_txn(1'b1, 16'h3000 + 16'(k * 16), 1'b0, '0);
         expect_txn(1'b0, 16'h1000 + 16'(k * 16), 1'b0, '0);
      end
      wait_drain("contention");

      // Read and write together: write wins.
      push_d(16'h4008, 1'b1, 1'b1, {8{16'h1234}});
      expect_txn(1'b1, 16'h4000, 1'b1, {8{16'h1234}});
      wait_drain("rd_wr_both");

      // Reset during SERVE_I abandons the fill.
      push_i(16'h5000);
      step();
      step();
      chk("abort_pre_read", pmem_read, 1);
      rst = 1'b1;
      i_q.delete();
      step();
      chk("abort_idle", {pmem_read, pmem_write, i_resp}, '0);
      rst = 1'b0;
      repeat (6) step();
      chk("abort_no_resp_pending", exp_q.size(), 0);
      push_d(16'h6004, 1'b1, 1'b0, '0);
      expect_txn(1'b1, 16'h6000, 1'b0, '0);
      wait_drain("after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
